condlogic_mc: RTL and testbench

CONDLOGIC_MC -- requirements
Module: condlogic_mc

---
 rtl/condlogic_mc.sv | 74 +++++++
 tb/tb_condlogic_mc.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/condlogic_mc.sv
// condlogic_mc: condition evaluation, NZCV flag register and gated write enables
module condlogic_mc #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Cond,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagW,
    input  logic        CondLatch,
    input  logic        PCS,
    input  logic        NextPC,
    input  logic        RegW,
    input  logic        MemW,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [3:0]  Flags,
    output logic        CondExReg,
    output logic [15:0] SkipCount
);
    logic [3:0]  r_flags;
    logic        r_cond_ex;
    logic [15:0] r_skip;
    logic        w_cond_ex;
    logic        w_n, w_z, w_c, w_v, w_ge;

    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign w_ge = (w_n == w_v);

    // condition decode from registered flags only
    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~(w_c & ~w_z);
            4'b1010: w_cond_ex = w_ge;
            4'b1011: w_cond_ex = ~w_ge;
            4'b1100: w_cond_ex = ~w_z & w_ge;
            4'b1101: w_cond_ex = ~(~w_z & w_ge);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // flags gated by the pre-edge latched condition; latch and skip counter on decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags   <= FLAG_RESET;
            r_cond_ex <= 1'b0;
            r_skip    <= 16'd0;
        end else begin
            if (FlagW[1] && r_cond_ex) r_flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0] && r_cond_ex) r_flags[1:0] <= ALUFlags[1:0];
            if (CondLatch) r_cond_ex <= w_cond_ex;
            if (CondLatch && !w_cond_ex && r_skip != 16'hFFFF) r_skip <= r_skip + 16'd1;
        end
    end

    assign PCWrite   = NextPC | (PCS & r_cond_ex);
    assign RegWrite  = RegW & r_cond_ex;
    assign MemWrite  = MemW & r_cond_ex;
    assign Flags     = r_flags;
    assign CondExReg = r_cond_ex;
    assign SkipCount = r_skip;
endmodule

// File: tb/tb_condlogic_mc.sv
// tb_condlogic_mc: randomized scoreboard bench for condlogic_mc
module tb_condlogic_mc;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  Cond = '0, ALUFlags = '0;
    logic [1:0]  FlagW = '0;
    logic        CondLatch = 0, PCS = 0, NextPC = 0, RegW = 0, MemW = 0;
    logic        PCWrite, RegWrite, MemWrite, CondExReg;
    logic [3:0]  Flags;
    logic [15:0] SkipCount;

    condlogic_mc #(.FLAG_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .CondLatch(CondLatch), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
        .CondExReg(CondExReg), .SkipCount(SkipCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] v;
        int          id;
    } exp_t;
    exp_t q[$];

    int n_pass = 0, n_total = 0, n_step = 0;

    logic [3:0]  m_flags = 4'b0000;
    logic        m_cer = 1'b0;
    int          m_skip = 0;

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, b;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return (c == 4'hF) ? 1'b0 : (c[0] ? !b : b);
    endfunction

    task automatic check(input string name, input int id, input logic [23:0] got, input logic [23:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s#%0d got %h exp %h", name, id, got, exp);
    endtask

    task automatic step(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                        input logic lat, input logic pcs, input logic np, input logic rw, input logic mw);
        exp_t e;
        logic ce;
        @(negedge clk);
        Cond = c; ALUFlags = alu; FlagW = fw; CondLatch = lat;
        PCS = pcs; NextPC = np; RegW = rw; MemW = mw;
        e.v = {np | (pcs & m_cer), rw & m_cer, mw & m_cer, m_flags, m_cer, 16'(m_skip)};
        e.id = n_step++;
        q.push_back(e);
        if (reset) begin
            ce = cond_eval(c, m_flags);
            if (fw[1] && m_cer) m_flags[3:2] = alu[3:2];
            if (fw[0] && m_cer) m_flags[1:0] = alu[1:0];
            if (lat) begin
                m_cer = ce;
                if (!ce && m_skip < 65535) m_skip++;
            end
        end
    endtask

    task automatic rnd_step(input logic lat_ok);
        step(4'($urandom), 4'($urandom), 2'($urandom), lat_ok & 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic model_reset();
        m_flags = 4'b0000;
        m_cer = 1'b0;
        m_skip = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("outputs", e.id, {PCWrite, RegWrite, MemWrite, Flags, CondExReg, SkipCount}, e.v);
            end
        end
    end

    initial begin : driver
        #1;
        check("async_reset_t0", 0, {Flags, CondExReg, SkipCount}, 21'd0);
        repeat (3) rnd_step(1'b1);
        @(negedge clk);
        reset = 1'b1;
        step(4'hE, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        step(4'h0, 4'h0, 2'b00, 0, 1, 0, 1, 1);
        step(4'h0, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
        step(4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        step(4'h1, 4'h0, 2'b00, 1, 0, 0, 1, 0);
        step(4'h0, 4'h0, 2'b00, 0, 0, 0, 1, 0);
        step(4'hE, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        step(4'h0, 4'b1001, 2'b11, 0, 0, 0, 0, 0);
        step(4'hA, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        step(4'h0, 4'b1101, 2'b11, 0, 0, 0, 0, 0);
        step(4'hC, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        step(4'hF, 4'h0, 2'b00, 1, 0, 1, 0, 0);
        step(4'h0, 4'b1111, 2'b11, 0, 1, 1, 1, 1);
        step(4'hE, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        step(4'h0, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
        step(4'h0, 4'b1111, 2'b01, 0, 0, 0, 0, 0);
        step(4'h0, 4'b1111, 2'b10, 0, 0, 0, 0, 0);
        step(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        repeat (400) rnd_step(1'b1);
        repeat (65540) step(4'hF, 4'($urandom), 2'($urandom), 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        step(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_mid", n_step, {Flags, CondExReg, SkipCount}, 21'd0);
        model_reset();
        repeat (3) rnd_step(1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) rnd_step(1'b0);
        repeat (300) rnd_step(1'b1);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        #3;
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
